// File: rtl/spi_subunit.sv
// spi_subunit: SPI mode-0 peripheral that runs entirely on the system clock.
//
// SPI_SCLK, SPI_CS and SPI_MOSI are oversampled through SYNC_STAGES-deep
// synchronizers, and one more registered copy is used for edge detection.
// A byte is shifted in MSB first on each synchronized SCLK rising edge.
// The byte from send_data is shifted out MSB first on SPI_MISO, changing on
// SCLK falling edges. Bytes run back to back while chip select stays low.
//
// Ports:
//   clk            system clock
//   rst            asynchronous active-high reset
//   SPI_SCLK       SPI clock from the controller (idle low)
//   SPI_CS         active-low chip select
//   SPI_MOSI       serial data from the controller, MSB first
//   SPI_MISO       serial data to the controller, MSB first
//   send_data      byte returned on MISO during the next byte slot
//   data_received  last complete byte captured from MOSI
//   received_valid one-clk pulse when data_received updates
//   busy           high while a selected transfer is in progress
//
// Parameter:
//   SYNC_STAGES    synchronizer depth on the SPI inputs (2..4)
//
// Build option:
//   SPI_SUBUNIT_MISO_TRISTATE_EN  when defined, SPI_MISO is high-impedance
//                                 outside ACTIVE; otherwise it drives 0.
//
// The SCLK half-period must be at least SYNC_STAGES+3 clk periods.

module spi_subunit #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       SPI_SCLK,
  input  logic       SPI_CS,
  input  logic       SPI_MOSI,
  output logic       SPI_MISO,
  input  logic [7:0] send_data,
  output logic [7:0] data_received,
  output logic       received_valid,
  output logic       busy
);

  typedef enum logic [1:0] {
    RESYNC = 2'd0,
    IDLE   = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_d, cs_d;
  logic [SYNC_STAGES:0]   prime_sr;
  logic [7:0]             tx;
  logic [6:0]             rx;
  logic [2:0]             bit_count;
  logic                   miso_drive;

  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall, primed;

  // Input synchronizers plus the extra copy used for edge detection.
  // CS resets to the deselected level so reset never looks like a select.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_sync   <= '1;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
      prime_sr  <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SPI_SCLK};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], SPI_MOSI};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], SPI_CS};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      cs_d      <= cs_sync[SYNC_STAGES-1];
      prime_sr  <= {prime_sr[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_rise   = cs_s & ~cs_d;
  assign cs_fall   = ~cs_s & cs_d;

  // The CS synchronizer comes out of reset holding the deselected value, so
  // a CS that is really low would briefly read high. RESYNC therefore waits
  // until the real pin level has propagated through the whole chain before
  // it trusts a high CS; otherwise a transfer already underway at reset
  // release would be picked up mid-byte.
  assign primed = prime_sr[SYNC_STAGES];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RESYNC;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      RESYNC: if (primed && cs_s) state_next = IDLE;
      IDLE:   if (cs_fall)        state_next = ACTIVE;
      ACTIVE: if (cs_rise)        state_next = IDLE;
      default:                    state_next = RESYNC;
    endcase
  end

  // Shift datapath. A CS rising edge wins over any SCLK edge in the same
  // cycle, so a deselect never completes or advances a byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx             <= '0;
      rx             <= '0;
      bit_count      <= '0;
      data_received  <= 8'h00;
      received_valid <= 1'b0;
    end else begin
      received_valid <= 1'b0;
      if (state == IDLE && cs_fall) begin
        tx        <= send_data;
        bit_count <= '0;
      end else if (state == ACTIVE && !cs_rise) begin
        if (sclk_rise) begin
          rx        <= {rx[5:0], mosi_s};
          bit_count <= bit_count + 3'd1;
          if (bit_count == 3'd7) begin
            data_received  <= {rx, mosi_s};
            received_valid <= 1'b1;
          end
        end else if (sclk_fall) begin
          // bit_count wraps to 0 after the 8th bit, so this falling edge
          // opens the next byte slot with a fresh send_data.
          if (bit_count == 3'd0) tx <= send_data;
          else                   tx <= {tx[6:0], 1'b0};
        end
      end
    end
  end

  // Output logic.
  always_comb begin
    busy       = (state == ACTIVE);
    miso_drive = (state == ACTIVE) ? tx[7] : 1'b0;
  end

`ifdef SPI_SUBUNIT_MISO_TRISTATE_EN
  assign SPI_MISO = (state == ACTIVE) ? miso_drive : 1'bz;
`else
  assign SPI_MISO = miso_drive;
`endif

endmodule

// File: tb/tb_spi_subunit.sv
// tb_spi_subunit: scoreboard bench for spi_subunit.
// The stimulus process acts as a mode-0 SPI controller and queues the bytes
// the DUT should capture. A separate monitor pops the queue on each
// received_valid pulse and compares.
`timescale 1ns/1ps

module tb_spi_subunit;

  localparam int SYNC = 2;
  localparam int HALF = 100;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk, cs, mosi;
  logic       spi_miso;
  logic [7:0] send_data;
  logic [7:0] data_received;
  logic       received_valid;
  logic       busy;

  int         check_count = 0;
  int         pass_count  = 0;
  int         valid_count = 0;
  logic       prev_valid  = 1'b0;
  logic [7:0] exp_q[$];
  logic       miso_idle;

  spi_subunit #(.SYNC_STAGES(SYNC)) dut (
    .clk           (clk),
    .rst           (rst),
    .SPI_SCLK      (sclk),
    .SPI_CS        (cs),
    .SPI_MOSI      (mosi),
    .SPI_MISO      (spi_miso),
    .send_data     (send_data),
    .data_received (data_received),
    .received_valid(received_valid),
    .busy          (busy)
  );

  // 100 MHz system clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    check_count++;
    if (act === exp) pass_count++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Monitor: every received_valid pulse must match the next queued byte and
  // must last exactly one clk.
  always @(negedge clk) begin
    if (received_valid === 1'b1) begin
      valid_count++;
      if (exp_q.size() == 0) begin
        check_count++;
        $display("[TB] FAIL unexpected received_valid: got %h, expected no pulse", data_received);
      end else begin
        checkOutput("rx byte", data_received, exp_q.pop_front());
      end
      checkOutput("valid width", {7'b0, prev_valid}, 8'h00);
    end
    prev_valid = received_valid;
  end

  // One full byte as a mode-0 controller: MOSI set while SCLK is low, MISO
  // sampled at the rising edge. With set_next, send_data is changed once
  // received_valid is seen after the 8th rising edge, before the falling
  // edge that reloads the DUT's tx register.
  task automatic applyStimulus(input logic [7:0] tx_byte, input bit set_next,
                               input logic [7:0] next_tx, output logic [7:0] rx_byte);
    bit seen;
    rx_byte = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      mosi = tx_byte[i];
      repeat (HALF) @(negedge clk);
      sclk = 1'b1;
      rx_byte[i] = spi_miso;
      if (i == 0 && set_next) begin
        seen = 1'b0;
        for (int c = 0; c < HALF; c++) begin
          @(negedge clk);
          if (received_valid && !seen) begin
            send_data = next_tx;
            seen = 1'b1;
          end
        end
        checkOutput("valid before reload", {7'b0, seen}, 8'h01);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      sclk = 1'b0;
    end
  endtask

  // Partial byte: n full SCLK periods, ending with SCLK low.
  task automatic clockBits(input logic [7:0] tx_byte, input int n);
    for (int i = 0; i < n; i++) begin
      mosi = tx_byte[7-i];
      repeat (HALF) @(negedge clk);
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] m0, m1, m2;
    int v0;

`ifdef SPI_SUBUNIT_MISO_TRISTATE_EN
    miso_idle = 1'bz;
`else
    miso_idle = 1'b0;
`endif

    rst = 1'b1; sclk = 1'b0; cs = 1'b1; mosi = 1'b0; send_data = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("reset busy", {7'b0, busy}, 8'h00);
    checkOutput("reset valid", {7'b0, received_valid}, 8'h00);
    checkOutput("reset data", data_received, 8'h00);
    checkOutput("reset miso", {7'b0, spi_miso}, {7'b0, miso_idle});
    rst = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("idle busy", {7'b0, busy}, 8'h00);

    // Single byte
    $display("[TB] single byte");
    send_data = 8'hA5;
    exp_q.push_back(8'h3C);
    cs = 1'b0;
    applyStimulus(8'h3C, 1'b0, 8'h00, m0);
    checkOutput("busy during xfer", {7'b0, busy}, 8'h01);
    checkOutput("single miso byte", m0, 8'hA5);
    repeat (HALF) @(negedge clk);
    cs = 1'b1;
    repeat (SYNC + 2) @(negedge clk);
    checkOutput("busy after single", {7'b0, busy}, 8'h00);
    checkOutput("miso after single", {7'b0, spi_miso}, {7'b0, miso_idle});

    // CS-held three-byte burst
    $display("[TB] burst");
    v0 = valid_count;
    send_data = 8'h10;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h03);
    cs = 1'b0;
    applyStimulus(8'h01, 1'b1, 8'h20, m0);
    applyStimulus(8'h02, 1'b1, 8'h30, m1);
    applyStimulus(8'h03, 1'b0, 8'h00, m2);
    checkOutput("burst miso 0", m0, 8'h10);
    checkOutput("burst miso 1", m1, 8'h20);
    checkOutput("burst miso 2", m2, 8'h30);
    repeat (HALF) @(negedge clk);
    cs = 1'b1;
    repeat (HALF) @(negedge clk);
    checkOutput("burst pulse count", 8'(valid_count - v0), 8'd3);

    // Abort after 5 rising edges
    $display("[TB] abort");
    v0 = valid_count;
    send_data = 8'h55;
    cs = 1'b0;
    clockBits(8'hF0, 5);
    cs = 1'b1;
    repeat (SYNC + 2) @(negedge clk);
    checkOutput("abort busy", {7'b0, busy}, 8'h00);
    checkOutput("abort data kept", data_received, 8'h03);
    repeat (HALF) @(negedge clk);
    checkOutput("abort no pulse", 8'(valid_count - v0), 8'd0);

    // Reset mid-transfer, released with CS low
    $display("[TB] reset mid-transfer");
    v0 = valid_count;
    cs = 1'b0;
    clockBits(8'hAA, 3);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("midreset data", data_received, 8'h00);
    checkOutput("midreset busy", {7'b0, busy}, 8'h00);
    rst = 1'b0;
    clockBits(8'hAA, 5);
    checkOutput("resync busy", {7'b0, busy}, 8'h00);
    checkOutput("resync no pulse", 8'(valid_count - v0), 8'd0);
    checkOutput("resync miso", {7'b0, spi_miso}, {7'b0, miso_idle});
    cs = 1'b1;
    repeat (HALF) @(negedge clk);
    send_data = 8'h5A;
    exp_q.push_back(8'hFF);
    cs = 1'b0;
    applyStimulus(8'hFF, 1'b0, 8'h00, m0);
    checkOutput("post-reset miso byte", m0, 8'h5A);
    repeat (HALF) @(negedge clk);
    cs = 1'b1;
    repeat (HALF) @(negedge clk);

    // SCLK toggling with CS high
    $display("[TB] sclk with cs high");
    v0 = valid_count;
    for (int i = 0; i < 8; i++) begin
      mosi = i[0];
      sclk = 1'b1;
      repeat (HALF / 2) @(negedge clk);
      checkOutput("deselected busy", {7'b0, busy}, 8'h00);
      checkOutput("deselected miso", {7'b0, spi_miso}, {7'b0, miso_idle});
      sclk = 1'b0;
      repeat (HALF / 2) @(negedge clk);
    end
    checkOutput("deselected no pulse", 8'(valid_count - v0), 8'd0);
    checkOutput("scoreboard drained", 8'(exp_q.size()), 8'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
